// File: rtl/abr_prim_sync_filter_pkg.sv
// Shared definitions for the synchronizer/glitch-filter primitive: edge
// classification and elaboration-time parameter helpers.
package abr_prim_sync_filter_pkg;

  typedef enum logic [1:0] {
    EdgeNone = 2'b00,
    EdgeRise = 2'b01,
    EdgeFall = 2'b10
  } edge_e;

  // Counter must hold FilterCycles-1; keep at least one bit so FilterCycles=1 still elaborates.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic bit sync_params_ok(input int stages, input int cycles);
    return (stages >= 2) && (cycles >= 1);
  endfunction

endpackage

// File: rtl/abr_prim_flop.sv
// Plain register with asynchronous active-low reset to a parameterised value.
module abr_prim_flop #(
  parameter int              Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_b,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      r_q <= ResetValue;
    end else begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/abr_prim_sync_filter_ch.sv
// Single-channel stability filter: commits a new level after FilterCycles
// consecutive mismatching samples and flags the commit with a rise/fall pulse.
module abr_prim_sync_filter_ch
  import abr_prim_sync_filter_pkg::*;
#(
  parameter int   FilterCycles = 4,
  parameter logic ResetValue   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_b,
  input  logic s_i,
  input  logic en_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CntW   = cnt_width(FilterCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_q;
  logic            r_rise;
  logic            r_fall;

  logic  w_mismatch;
  logic  w_commit;
  edge_e w_edge;

  // With the filter bypassed any mismatch commits at once; otherwise only the
  // last cycle of a full-length mismatch run does.
  always_comb begin
    w_mismatch = (s_i != r_q);
    w_commit   = w_mismatch && (!en_i || (r_cnt == CntMax));
    w_edge     = EdgeNone;
    if (w_commit) begin
      w_edge = s_i ? EdgeRise : EdgeFall;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      r_q    <= ResetValue;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= (w_edge == EdgeRise);
      r_fall <= (w_edge == EdgeFall);
      if (w_commit) begin
        r_q <= s_i;
      end
      if (!en_i || !w_mismatch || w_commit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign q_o    = r_q;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/abr_prim_sync_filter.sv
// Multi-channel input conditioner: NumStages-deep synchronizer per channel
// followed by a per-channel stability filter with edge pulses.
module abr_prim_sync_filter
  import abr_prim_sync_filter_pkg::*;
#(
  parameter int               Width             = 8,
  parameter int               NumStages         = 2,
  parameter int               FilterCycles      = 4,
  parameter logic [Width-1:0] ResetValue        = '0,
  parameter bit               EnablePrimCdcRand = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_b,
  input  logic [Width-1:0] d_i,
  input  logic [Width-1:0] filt_en_i,
  output logic [Width-1:0] q_sync_o,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  if (!sync_params_ok(NumStages, FilterCycles)) begin : gen_param_check
    $error("abr_prim_sync_filter: NumStages must be >= 2 and FilterCycles >= 1");
  end

  // w_stage[0] is the (optionally delayed) raw input, w_stage[k] is flop k's output.
  logic [Width-1:0] w_stage [NumStages+1];

`ifdef ABR_SIMULATION
  abr_prim_cdc_rand_delay #(
    .DataWidth (Width),
    .Enable    (EnablePrimCdcRand)
  ) u_cdc_rand_delay (
    .clk_i       (clk_i),
    .rst_ni      (rst_b),
    .src_data_i  (d_i),
    .prev_data_i (w_stage[1]),
    .dst_data_o  (w_stage[0])
  );
`else
  logic w_unused_cdc_rand;
  assign w_unused_cdc_rand = EnablePrimCdcRand;
  assign w_stage[0]        = d_i;
`endif

  for (genvar k = 0; k < NumStages; k++) begin : gen_stage
    abr_prim_flop #(
      .Width      (Width),
      .ResetValue (ResetValue)
    ) u_flop (
      .clk_i (clk_i),
      .rst_b (rst_b),
      .d_i   (w_stage[k]),
      .q_o   (w_stage[k+1])
    );
  end

  assign q_sync_o = w_stage[NumStages];

  for (genvar c = 0; c < Width; c++) begin : gen_ch
    abr_prim_sync_filter_ch #(
      .FilterCycles (FilterCycles),
      .ResetValue   (ResetValue[c])
    ) u_ch (
      .clk_i  (clk_i),
      .rst_b  (rst_b),
      .s_i    (w_stage[NumStages][c]),
      .en_i   (filt_en_i[c]),
      .q_o    (q_o[c]),
      .rise_o (rise_o[c]),
      .fall_o (fall_o[c])
    );
  end

endmodule
